// File: rtl/booth_r4_seq_ctrl.sv
// -----------------------------------------------------------------------------
// booth_r4_seq_ctrl
//
// Iterative radix-4 Booth multiplier controller for signed WIDTH x WIDTH
// operands. An accepted start latches the operands. Each CALC cycle then
// recodes one multiplier digit, selects one of {0, +M, -M, +2M, -2M}, and
// accumulates that variant, shifted into place, into a 2*WIDTH product register.
//
// Optional feature macro: BOOTH_EARLY_EXIT_EN
//   When defined, CALC ends as soon as the unprocessed multiplier bits are all
//   equal, because every remaining digit then recodes to zero.
//   When undefined, CALC always lasts exactly WIDTH/2 cycles.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset; aborts any operation in flight
//   start    request, accepted in IDLE or DONE (ignored while busy)
//   m_in     signed multiplicand, sampled on an accepted start
//   q_in     signed multiplier, sampled on an accepted start
//   busy     high while iterating (CALC)
//   done     one-cycle pulse when product is final
//   product  signed 2*WIDTH result, driven from the accumulator
//   iter     number of digits processed so far
// -----------------------------------------------------------------------------
module booth_r4_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2)+1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   m_in,
  input  logic [WIDTH-1:0]   q_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [CNT_W-1:0]   iter
);

  localparam int PW     = 2*WIDTH;
  localparam int DIGITS = WIDTH/2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q,     m_d;
  // Multiplier with the implicit q[-1]=0 appended at bit 0.
  logic [WIDTH:0]   q_q,     q_d;
  logic [PW-1:0]    acc_q,   acc_d;
  logic [CNT_W-1:0] iter_q,  iter_d;

  logic [CNT_W:0]   shamt;
  logic [2:0]       trip;
  logic [PW-1:0]    m_ext;
  logic [PW-1:0]    variant;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_base;
  logic             rest_zero;

  // Digit i sits at multiplier bit 2i. In the appended register the triplet
  // {q[2i+1], q[2i], q[2i-1]} is therefore q_q[2i+2 : 2i].
  assign shamt = {iter_q, 1'b0};
  assign trip  = q_q[shamt +: 3];

  // Sign-extend before any negation or shift, so that -M of the most-negative
  // operand wraps correctly in 2*WIDTH bits.
  assign m_ext = {{WIDTH{m_q[WIDTH-1]}}, m_q};

  always_comb begin
    variant = '0;
    unique case (trip)
      3'b001, 3'b010: variant = m_ext;
      3'b011:         variant = m_ext << 1;
      3'b100:         variant = -(m_ext << 1);
      3'b101, 3'b110: variant = -m_ext;
      default:        variant = '0;
    endcase
  end

  assign addend = variant << shamt;

  // The accumulator is cleared by the first CALC edge rather than the accept
  // edge. This keeps the previous product visible during the accept cycle.
  assign acc_base = (iter_q == '0) ? '0 : acc_q;

`ifdef BOOTH_EARLY_EXIT_EN
  // After this edge, the next digit index is iter_q+1. The unprocessed bits
  // q[WIDTH-1 : 2(iter_q+1)-1] are q_q[WIDTH : 2(iter_q+1)]. An arithmetic
  // shift leaves them in place; they are all equal exactly when the result
  // is all zeros or all ones.
  logic [CNT_W:0]        nshamt;
  logic signed [WIDTH:0] q_rem;

  assign nshamt    = {iter_q + 1'b1, 1'b0};
  assign q_rem     = $signed(q_q) >>> nshamt;
  assign rest_zero = (q_rem == '0) || (q_rem == '1);
`else
  assign rest_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = m_in;
          q_d     = {q_in, 1'b0};
          iter_d  = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d  = acc_base + addend;
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST || rest_zero) state_d = S_DONE;
      end
      S_DONE: begin
        // A start held high here chains the next operation with no idle cycle.
        if (start) begin
          m_d     = m_in;
          q_d     = {q_in, 1'b0};
          iter_d  = '0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
    end
  end

  assign busy    = (state_q == S_CALC);
  assign done    = (state_q == S_DONE);
  assign product = acc_q;
  assign iter    = iter_q;

endmodule
